// File: rtl/divisor_pkg.sv
// Shared defaults and derived widths for the programmable clock divider.
package divisor_pkg;

  localparam int LARGURA_PADRAO   = 30;
  localparam int DIV_RESET_PADRAO = 0;

  // A single channel still needs a 1-bit index port.
  function automatic int calc_canal_w(input int n_canais);
    return (n_canais > 1) ? $clog2(n_canais) : 1;
  endfunction

endpackage

// File: rtl/canal_divisor.sv
// One divider channel: counter, active/shadow divisor, tick pulse and square wave.
// Outputs registered, one cycle after the deciding edge; no backpressure (free-running).
module canal_divisor
  import divisor_pkg::*;
#(
  parameter int                 LARGURA   = LARGURA_PADRAO,
  parameter logic [LARGURA-1:0] DIV_RESET = LARGURA'(DIV_RESET_PADRAO)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               habilita_i,
  input  logic               wr_i,
  input  logic [LARGURA-1:0] wr_valor_i,
  output logic               tick_o,
  output logic               onda_o
);

  logic [LARGURA-1:0] contador_q, contador_d;
  logic [LARGURA-1:0] d_ativo_q, d_ativo_d;
  logic [LARGURA-1:0] d_sombra_q, d_sombra_d;
  logic               tick_q, tick_d;
  logic               onda_q, onda_d;

  always_comb begin
    contador_d = contador_q;
    d_ativo_d  = d_ativo_q;
    d_sombra_d = wr_i ? wr_valor_i : d_sombra_q;
    tick_d     = 1'b0;
    onda_d     = onda_q;

    if (d_ativo_q == '0) begin
      contador_d = '0;
      onda_d     = 1'b0;
      if (wr_i) begin
        d_ativo_d = wr_valor_i;
      end
    end else if (habilita_i) begin
      if (contador_q == d_ativo_q - LARGURA'(1)) begin
        contador_d = '0;
        tick_d     = 1'b1;
        onda_d     = ~onda_q;
        // A write landing on the wrap edge takes effect immediately.
        d_ativo_d  = wr_i ? wr_valor_i : d_sombra_q;
      end else begin
        contador_d = contador_q + LARGURA'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contador_q <= '0;
      d_ativo_q  <= DIV_RESET;
      d_sombra_q <= DIV_RESET;
      tick_q     <= 1'b0;
      onda_q     <= 1'b0;
    end else begin
      contador_q <= contador_d;
      d_ativo_q  <= d_ativo_d;
      d_sombra_q <= d_sombra_d;
      tick_q     <= tick_d;
      onda_q     <= onda_d;
    end
  end

  assign tick_o = tick_q;
  assign onda_o = onda_q;

endmodule

// File: rtl/divisor_programavel.sv
// Multi-channel programmable divider: write decode, ack/error pulses, N independent channels.
// wr_ack/wr_erro one cycle after wr_en; writes always accepted or rejected, never stalled.
module divisor_programavel
  import divisor_pkg::*;
#(
  parameter int                 N_CANAIS  = 2,
  parameter int                 LARGURA   = LARGURA_PADRAO,
  parameter logic [LARGURA-1:0] DIV_RESET = LARGURA'(DIV_RESET_PADRAO),
  localparam int                CANAL_W   = calc_canal_w(N_CANAIS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CANAIS-1:0] habilita,
  input  logic                wr_en,
  input  logic [CANAL_W-1:0]  wr_canal,
  input  logic [LARGURA-1:0]  wr_valor,
  output logic                wr_ack,
  output logic                wr_erro,
  output logic [N_CANAIS-1:0] tick,
  output logic [N_CANAIS-1:0] onda
);

  logic wr_valido;
  logic wr_ack_q, wr_ack_d;
  logic wr_erro_q, wr_erro_d;

  // Indices beyond N_CANAIS are representable when N_CANAIS is not a power of two.
  assign wr_valido = wr_en && (int'(wr_canal) < N_CANAIS);
  assign wr_ack_d  = wr_valido;
  assign wr_erro_d = wr_en && !wr_valido;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack_q  <= 1'b0;
      wr_erro_q <= 1'b0;
    end else begin
      wr_ack_q  <= wr_ack_d;
      wr_erro_q <= wr_erro_d;
    end
  end

  assign wr_ack  = wr_ack_q;
  assign wr_erro = wr_erro_q;

  for (genvar i = 0; i < N_CANAIS; i++) begin : g_canal
    canal_divisor #(
      .LARGURA   (LARGURA),
      .DIV_RESET (DIV_RESET)
    ) u_canal (
      .clk        (clk),
      .rst_n      (rst_n),
      .habilita_i (habilita[i]),
      .wr_i       (wr_valido && (wr_canal == CANAL_W'(i))),
      .wr_valor_i (wr_valor),
      .tick_o     (tick[i]),
      .onda_o     (onda[i])
    );
  end

endmodule

// File: tb/tb_divisor_programavel.sv
// Directed bench for divisor_programavel with three channels and hand-computed tick/onda traces.
module tb_divisor_programavel;

  localparam int N = 3;
  localparam int L = 30;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  habilita;
  logic          wr_en;
  logic [1:0]    wr_canal;
  logic [L-1:0]  wr_valor;
  logic          wr_ack;
  logic          wr_erro;
  logic [N-1:0]  tick;
  logic [N-1:0]  onda;

  int total = 0;
  int bad   = 0;

  logic [63:0] rec_tk [N];
  logic [63:0] rec_on [N];

  divisor_programavel #(
    .N_CANAIS  (N),
    .LARGURA   (L),
    .DIV_RESET ('0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .habilita (habilita),
    .wr_en    (wr_en),
    .wr_canal (wr_canal),
    .wr_valor (wr_valor),
    .wr_ack   (wr_ack),
    .wr_erro  (wr_erro),
    .tick     (tick),
    .onda     (onda)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled and inputs changed 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bit k-1 of each trace holds the output after the k-th edge.
  task automatic run_rec(input int n);
    for (int c = 0; c < N; c++) begin
      rec_tk[c] = '0;
      rec_on[c] = '0;
    end
    for (int k = 0; k < n; k++) begin
      step();
      for (int c = 0; c < N; c++) begin
        rec_tk[c][k] = tick[c];
        rec_on[c][k] = onda[c];
      end
    end
  endtask

  task automatic wr(input logic [1:0] c, input logic [L-1:0] v);
    wr_en    = 1'b1;
    wr_canal = c;
    wr_valor = v;
  endtask

  initial begin
    habilita = '0;
    wr_en    = 1'b0;
    wr_canal = '0;
    wr_valor = '0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_tick", 64'(tick), 64'h0);
    chk("rst_onda", 64'(onda), 64'h0);
    chk("rst_ack", 64'(wr_ack), 64'h0);
    chk("rst_erro", 64'(wr_erro), 64'h0);
    #20 rst_n = 1'b1;
    step();

    // Halted ch0 receives D=4: loads at once, ticks every 4th cycle.
    habilita = 3'b001;
    wr(2'd0, 30'd4);
    step();
    chk("d4_ack", 64'(wr_ack), 64'h1);
    chk("d4_erro", 64'(wr_erro), 64'h0);
    wr_en = 1'b0;
    step();
    chk("d4_ack_pulse", 64'(wr_ack), 64'h0);
    run_rec(11);
    chk("d4_tick0", rec_tk[0], 64'h444);
    chk("d4_onda0", rec_on[0], 64'h43C);
    chk("d4_ch12_quiet", rec_tk[1] | rec_tk[2] | rec_on[1] | rec_on[2], 64'h0);

    // Retune to D=2 mid-period: current period still lasts 4 cycles.
    step();
    wr(2'd0, 30'd2);
    step();
    chk("d2_ack", 64'(wr_ack), 64'h1);
    wr_en = 1'b0;
    run_rec(8);
    chk("d2_tick0", rec_tk[0], 64'hAA);
    chk("d2_onda0", rec_on[0], 64'h99);

    // D=5 becomes active, then D=3 written in the wrap cycle goes straight in.
    wr(2'd0, 30'd5);
    step();
    wr_en = 1'b0;
    run_rec(5);
    chk("d5_tick0", rec_tk[0], 64'h01);
    wr(2'd0, 30'd3);
    step();
    chk("wrapwr_tick0", 64'(tick[0]), 64'h1);
    wr_en = 1'b0;
    run_rec(6);
    chk("wrapwr_d3_tick0", rec_tk[0], 64'h24);

    // Pause at contador=2 with D=5 for 10 cycles.
    wr(2'd0, 30'd5);
    step();
    wr_en = 1'b0;
    run_rec(4);
    chk("pre_pause_tick0", rec_tk[0], 64'h2);
    chk("pre_pause_onda0", rec_on[0], 64'h1);
    habilita = 3'b000;
    run_rec(10);
    chk("pause_tick0", rec_tk[0], 64'h0);
    chk("pause_onda0", rec_on[0], 64'h0);
    habilita = 3'b001;
    run_rec(5);
    chk("resume_tick0", rec_tk[0], 64'h04);
    chk("resume_onda0", rec_on[0], 64'h1C);

    // Out-of-range index is rejected; ch1 write leaves ch0 timing alone.
    wr(2'd3, 30'd7);
    step();
    chk("bad_idx_ack", 64'(wr_ack), 64'h0);
    chk("bad_idx_erro", 64'(wr_erro), 64'h1);
    wr_en = 1'b0;
    step();
    chk("bad_idx_erro_pulse", 64'(wr_erro), 64'h0);
    habilita = 3'b011;
    wr(2'd1, 30'd3);
    step();
    chk("ch1_ack", 64'(wr_ack), 64'h1);
    chk("ch0_wrap_on_ch1_wr", 64'(tick[0]), 64'h1);
    wr_en = 1'b0;
    run_rec(10);
    chk("indep_tick0", rec_tk[0], 64'h210);
    chk("indep_tick1", rec_tk[1], 64'h124);
    chk("indep_tick2", rec_tk[2], 64'h0);

    // Writing 0 to running ch1 halts it after its next wrap.
    wr(2'd1, 30'd0);
    step();
    chk("d0_ack", 64'(wr_ack), 64'h1);
    wr_en = 1'b0;
    run_rec(4);
    chk("d0_tick1", rec_tk[1], 64'h1);
    chk("d0_onda1", rec_on[1], 64'h0);
    chk("d0_tick0", rec_tk[0], 64'h8);
    chk("d0_onda0", rec_on[0], 64'h8);

    // Asynchronous reset between edges clears outputs and restores D=0.
    habilita = 3'b111;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_tick", 64'(tick), 64'h0);
    chk("arst_onda", 64'(onda), 64'h0);
    chk("arst_ack", 64'(wr_ack), 64'h0);
    #2 rst_n = 1'b1;
    run_rec(6);
    chk("post_rst_halted", rec_tk[0] | rec_tk[1] | rec_tk[2] | rec_on[0] | rec_on[1] | rec_on[2], 64'h0);
    wr(2'd0, 30'd2);
    step();
    wr_en = 1'b0;
    run_rec(4);
    chk("post_rst_d2_tick0", rec_tk[0], 64'hA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
